melody_player: RTL

- Parametrised alarm-tone sequencer for the alarm clock.
- Holds a bank of NUM_SONGS melodies in a synchronous note ROM and steps through the selected song at a fixed slot rate.
- Drives a note code (0 = rest) to the downstream tone generator.
- Adds start/stop control, song select, loop mode, an end-of-song marker and a done pulse.

---
 rtl/melody_pkg.sv | 13 +
 rtl/melody_rom_bank.sv | 46 ++++
 rtl/melody_player.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared constants and FSM state encoding for the alarm-tone melody sequencer.
package melody_pkg;

    localparam logic [31:0] END_CODE  = '1;
    localparam logic [31:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2
    } state_t;

endpackage

// File: rtl/melody_rom_bank.sv
// Fixed melody bank: synchronous case-table ROM, one-cycle latency, END_CODE outside stored songs.
module melody_rom_bank
    import melody_pkg::*;
#(
    parameter int unsigned NOTE_W    = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned NUM_SONGS = 4
)(
    input  logic              clk,
    input  logic [SEL_W-1:0]  song,
    input  logic [ADDR_W-1:0] addr,
    output logic [NOTE_W-1:0] data
);

    localparam int unsigned SONG0_LEN = 28;
    localparam int unsigned SONG1_LEN = 8;
    localparam int unsigned SONG0 [SONG0_LEN] = '{
        22, 0, 22, 0, 29, 0, 29, 0, 19, 0, 19, 0, 29, 0,
        27, 0, 27, 0, 26, 0, 26, 0, 24, 0, 24, 0, 22, 0
    };
    localparam int unsigned SONG1 [SONG1_LEN] = '{16, 18, 20, 21, 23, 25, 27, 28};

    int unsigned       s_idx;
    int unsigned       a_idx;
    logic [NOTE_W-1:0] data_c;

    // Anything past a song's stored slots, or in a reserved song, reads as END.
    always_comb begin
        s_idx  = 32'(song);
        a_idx  = 32'(addr);
        data_c = NOTE_W'(END_CODE);
        if (s_idx < NUM_SONGS) begin
            if (s_idx == 0 && a_idx < SONG0_LEN) begin
                data_c = NOTE_W'(SONG0[5'(a_idx)]);
            end else if (s_idx == 1 && a_idx < SONG1_LEN) begin
                data_c = NOTE_W'(SONG1[3'(a_idx)]);
            end
        end
    end

    always_ff @(posedge clk) begin
        data <= data_c;
    end

endmodule

// File: rtl/melody_player.sv
// Alarm-tone sequencer: steps the selected melody one slot per TICK_DIV cycles,
// with start/stop, loop mode and a done pulse on natural completion.
module melody_player
    import melody_pkg::*;
#(
    parameter  int unsigned NOTE_W    = 8,
    parameter  int unsigned ADDR_W    = 5,
    parameter  int unsigned NUM_SONGS = 4,
    parameter  int unsigned TICK_DIV  = 12500000,
    localparam int unsigned SEL_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [SEL_W-1:0]  song_sel,
    output logic [NOTE_W-1:0] note,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] slot_addr
);

    localparam int unsigned       CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 2);
    localparam logic [NOTE_W-1:0] END_NOTE = NOTE_W'(END_CODE);
    localparam logic [NOTE_W-1:0] REST     = NOTE_W'(NOTE_REST);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic                wrap, wrap_n;
    logic [SEL_W-1:0]    song, song_n;
    logic                pend, pend_n;
    logic [NOTE_W-1:0]   note_n;
    logic [ADDR_W-1:0]   slot_n;
    logic                busy_n, done_n;
    logic [NOTE_W-1:0]   rom_data;
    logic                song_end_c;

    // ROM is addressed with next-cycle values so data is ready when FETCH ends.
    melody_rom_bank #(
        .NOTE_W    (NOTE_W),
        .ADDR_W    (ADDR_W),
        .SEL_W     (SEL_W),
        .NUM_SONGS (NUM_SONGS)
    ) u_rom (
        .clk  (clk),
        .song (song_n),
        .addr (addr_n),
        .data (rom_data)
    );

    assign song_end_c = (rom_data == END_NOTE) || wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr      <= '0;
            wrap      <= 1'b0;
            song      <= '0;
            pend      <= 1'b0;
            note      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            slot_addr <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            addr      <= addr_n;
            wrap      <= wrap_n;
            song      <= song_n;
            pend      <= pend_n;
            note      <= note_n;
            busy      <= busy_n;
            done      <= done_n;
            slot_addr <= slot_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr;
        wrap_n  = wrap;
        song_n  = song;
        pend_n  = pend;
        note_n  = note;
        slot_n  = slot_addr;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                // An accepted start spends one cycle latching the song before FETCH.
                busy_n = 1'b0;
                if (stop) begin
                    pend_n = 1'b0;
                end else if (pend) begin
                    pend_n  = 1'b0;
                    state_n = FETCH;
                    addr_n  = '0;
                    wrap_n  = 1'b0;
                    busy_n  = 1'b1;
                end else if (start) begin
                    pend_n = 1'b1;
                    song_n = song_sel;
                end
            end
            FETCH: begin
                cnt_n = '0;
                if (song_end_c) begin
                    note_n = REST;
                    slot_n = '0;
                    addr_n = '0;
                    wrap_n = 1'b0;
                    if (loop_en) begin
                        state_n = FETCH;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    note_n  = rom_data;
                    slot_n  = addr;
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n            = '0;
                    {wrap_n, addr_n} = {1'b0, addr} + (ADDR_W + 1)'(1);
                    state_n          = FETCH;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (stop && state != IDLE) begin
            state_n = IDLE;
            pend_n  = 1'b0;
            note_n  = REST;
            slot_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

endmodule
